parallel_serial_tx: RTL and testbench
=====================================

Name: parallel_serial_tx

Overview:
- Byte-to-bitstream serializer. Sits directly upstream of the serial-to-parallel receiver and drives its serial input.
- After reset it sends a burst of COMMA (0xBC) bytes so the receiver can lock byte alignment.
- It then sends user bytes MSB-first using a valid/ready handshake.
- In any byte slot with no user data, it inserts a COMMA filler byte, so the line never stalls.

Parameters:
- COMMA, 8'hBC, alignment/filler byte; must match the receiver's comma value.
- SYNC_COUNT, 4, number of COMMA bytes sent after reset before user data is accepted; legal range 1..255.

Ports:
- CLK  input  1  clock; one serial bit per cycle.
- RESET  input  1  synchronous, active-high reset.
- DATA_IN  input  8  parallel byte to transmit.
- VALID_IN  input  1  DATA_IN holds a valid byte.
- READY_OUT  output  1  block accepts DATA_IN at this clock edge if VALID_IN=1.
- DATA_OUT  output  1  serial bitstream, MSB of each byte first.
- LOCKED_OUT  output  1  high once the sync burst is complete (state RUN).

Behaviour:
- Internal state:
  - shreg[7:0], shift register.
  - bit_cnt[2:0], bit index within the current byte.
  - sync_cnt[7:0], completed sync commas.
  - state: SYNC or RUN.
- DATA_OUT = shreg[7], combinational from the register; no extra pipeline stage.
- Reset (RESET=1 at posedge) sets: shreg=COMMA, bit_cnt=0, sync_cnt=0, state=SYNC.
- Output values while in reset: DATA_OUT=COMMA[7] (1 for 0xBC), READY_OUT=0, LOCKED_OUT=0.
- Reset has priority over everything. Reset mid-byte aborts the byte with no completion, and the next line activity is a fresh sync burst.
- Each non-reset posedge with bit_cnt != 7: shreg <= {shreg[6:0],1'b0}; bit_cnt <= bit_cnt+1.
- Each non-reset posedge with bit_cnt == 7 (byte boundary): bit_cnt <= 0 and shreg loads the next byte:
  - DATA_IN if VALID_IN && READY_OUT;
  - otherwise COMMA (filler).
- Every byte occupies exactly 8 consecutive cycles. Bytes follow back-to-back with no gap bits.
- READY_OUT = (bit_cnt==7) && (state==RUN || sync_cnt==SYNC_COUNT-1).
  - READY_OUT is a one-cycle pulse, once per 8 cycles.
  - The first pulse falls in the last bit of the final sync comma.
- Handshake rules:
  - Transfer happens only on a posedge where VALID_IN=1 and READY_OUT=1.
  - If VALID_IN is high while READY_OUT is low, nothing is consumed. The source must hold DATA_IN/VALID_IN stable until the transfer.
  - If VALID_IN is low at a READY pulse, a COMMA filler is sent.
- Latency: a byte accepted at edge T appears on DATA_OUT in cycles T+1..T+8 (MSB in T+1).
- State machine:
  - SYNC: at each byte boundary, sync_cnt <= sync_cnt+1. When sync_cnt==SYNC_COUNT-1 at a boundary, go to RUN.
  - RUN: stays in RUN until RESET.
  - LOCKED_OUT = (state==RUN).
- Boundary cases:
  - DATA_IN equal to COMMA is sent unmodified; no escaping is applied.
  - VALID_IN asserted during SYNC is ignored until the first READY pulse.
  - sync_cnt does not advance in RUN, so it cannot wrap.
  - SYNC_COUNT=1 gives exactly one sync comma, with the first READY in that comma's bit 7.

Optional Feature:
- Macro PS_TX_FILL_STATS_EN.
- When defined:
  - Adds output port FILL_CNT [15:0].
  - FILL_CNT counts COMMA fillers inserted in RUN (boundaries where READY_OUT=1 and VALID_IN=0).
  - Sync commas are not counted.
  - The counter saturates at 16'hFFFF and resets to 0 on RESET.
- When undefined: no FILL_CNT port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset release, VALID_IN=0, SYNC_COUNT=4 -> DATA_OUT shows 0xBC (1,0,1,1,1,1,0,0) repeated 4 times. READY_OUT pulses at cycle 31. LOCKED_OUT rises after edge 32. Filler 0xBC continues.
- VALID_IN=1 held with DATA_IN=0xA5 from cycle 0 -> no transfer until the READY pulse at cycle 31. Bits 1,0,1,0,0,1,0,1 appear in cycles 32..39.
- Back-to-back bytes 0x3C, 0xFF, 0x00, each presented at consecutive READY pulses -> 24 contiguous bits, no filler between them; READY_OUT period is exactly 8 cycles.
- Gap: send 0x81, drop VALID_IN for one slot, then send 0x7E -> stream is 0x81, 0xBC, 0x7E. With PS_TX_FILL_STATS_EN, FILL_CNT increments by 1 for the gap.
- RESET asserted at bit 3 of a 0x55 byte -> READY_OUT=0 and LOCKED_OUT=0 immediately; shreg reloads COMMA. After release, a full 4-comma sync precedes any data.
- DATA_IN=0xBC sent as data in RUN -> transmitted verbatim; with PS_TX_FILL_STATS_EN, FILL_CNT is unchanged.

Source files
------------

// File: rtl/parallel_serial_tx.sv
// parallel_serial_tx: byte-to-bitstream serializer, MSB first, one bit per CLK.
// After reset it sends SYNC_COUNT COMMA bytes so the downstream receiver can lock
// byte alignment. It then accepts user bytes through a valid/ready handshake,
// inserting a COMMA filler in any byte slot that has no user data.
// Optional feature: define PS_TX_FILL_STATS_EN to add the FILL_CNT output, a
// saturating count of filler commas inserted after the sync burst.
module parallel_serial_tx #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  DATA_IN,
  input  logic        VALID_IN,
  output logic        READY_OUT,
  output logic        DATA_OUT,
  output logic        LOCKED_OUT
`ifdef PS_TX_FILL_STATS_EN
  ,
  output logic [15:0] FILL_CNT
`endif
);

  typedef enum logic {ST_SYNC, ST_RUN} state_t;

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_COUNT - 1);

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sync_cnt_q, sync_cnt_d;
  state_t     state_q, state_d;

  logic boundary;
  logic ready;
  logic take;

  assign boundary = (bit_cnt_q == 3'd7);
  // The first ready pulse lands in the last bit of the final sync comma.
  assign ready    = boundary && ((state_q == ST_RUN) || (sync_cnt_q == SYNC_LAST));
  assign take     = ready && VALID_IN;

  // Ready is held low during the reset cycle itself so no source ever sees a
  // handshake that the reset is about to discard.
  assign READY_OUT  = ready && !RESET;
  assign DATA_OUT   = shreg_q[7];
  assign LOCKED_OUT = (state_q == ST_RUN);

  // Next-state: shift within a byte, load user data or filler at the boundary.
  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    sync_cnt_d = sync_cnt_q;
    state_d    = state_q;
    if (boundary) begin
      bit_cnt_d = 3'd0;
      shreg_d   = take ? DATA_IN : COMMA;
      if (state_q == ST_SYNC) begin
        sync_cnt_d = sync_cnt_q + 8'd1;
        if (sync_cnt_q == SYNC_LAST) state_d = ST_RUN;
      end
    end else begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shreg_d   = {shreg_q[6:0], 1'b0};
    end
  end

  // State registers; synchronous reset restarts a full sync burst.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shreg_q    <= COMMA;
      bit_cnt_q  <= 3'd0;
      sync_cnt_q <= 8'd0;
      state_q    <= ST_SYNC;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      state_q    <= state_d;
    end
  end

`ifdef PS_TX_FILL_STATS_EN
  logic [15:0] fill_cnt_q, fill_cnt_d;

  // Count filler slots: a ready pulse with no user byte offered; saturates.
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (ready && !VALID_IN && (fill_cnt_q != 16'hFFFF)) fill_cnt_d = fill_cnt_q + 16'd1;
  end

  // Filler counter register.
  always_ff @(posedge CLK) begin
    if (RESET) fill_cnt_q <= 16'd0;
    else       fill_cnt_q <= fill_cnt_d;
  end

  assign FILL_CNT = fill_cnt_q;
`endif

endmodule

// File: tb/tb_parallel_serial_tx.sv
// Directed testbench for parallel_serial_tx (COMMA=0xBC, SYNC_COUNT=4).
// Cycle c counts from the first cycle after reset release; slot = c/8, bit = c%8.
// Inputs for slot s+1 are presented throughout slot s, so VALID_IN is held well
// before each ready pulse and must be ignored outside it.
module tb_parallel_serial_tx;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  DATA_IN;
  logic        VALID_IN;
  logic        READY_OUT;
  logic        DATA_OUT;
  logic        LOCKED_OUT;
`ifdef PS_TX_FILL_STATS_EN
  logic [15:0] FILL_CNT;
`endif

  int n_run  = 0;
  int n_fail = 0;

  parallel_serial_tx #(.COMMA(8'hBC), .SYNC_COUNT(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DATA_IN    (DATA_IN),
    .VALID_IN   (VALID_IN),
    .READY_OUT  (READY_OUT),
    .DATA_OUT   (DATA_OUT),
    .LOCKED_OUT (LOCKED_OUT)
`ifdef PS_TX_FILL_STATS_EN
    ,
    .FILL_CNT   (FILL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Two reset edges, then release: caller is left at cycle 0.
  task automatic do_reset();
    RESET = 1'b1; VALID_IN = 1'b0; DATA_IN = 8'h00;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; VALID_IN = 1'b1; DATA_IN = 8'h00;
    tick();
    n_run++; if (DATA_OUT !== 1'b1) begin n_fail++; $display("FAIL reset_data_out got=%b exp=1", DATA_OUT); end
    n_run++; if (READY_OUT !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", READY_OUT); end
    n_run++; if (LOCKED_OUT !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b exp=0", LOCKED_OUT); end
`ifdef PS_TX_FILL_STATS_EN
    n_run++; if (FILL_CNT !== 16'd0) begin n_fail++; $display("FAIL reset_fill got=%0d exp=0", FILL_CNT); end
`endif
    tick();
    RESET = 1'b0; VALID_IN = 1'b0;
  endtask

  task automatic test_sync();
    logic [7:0] e;
    logic       er;
    int s, b;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      s = c / 8; b = c % 8;
      VALID_IN = 1'b0; DATA_IN = 8'h00;
      e  = 8'hBC;
      er = (b == 7) && (s >= 3);
      n_run++; if (DATA_OUT !== e[7-b]) begin n_fail++; $display("FAIL sync_bit c=%0d got=%b exp=%b", c, DATA_OUT, e[7-b]); end
      n_run++; if (READY_OUT !== er) begin n_fail++; $display("FAIL sync_ready c=%0d got=%b exp=%b", c, READY_OUT, er); end
      n_run++; if (LOCKED_OUT !== (c >= 32)) begin n_fail++; $display("FAIL sync_locked c=%0d got=%b", c, LOCKED_OUT); end
`ifdef PS_TX_FILL_STATS_EN
      if (c == 31) begin n_run++; if (FILL_CNT !== 16'd0) begin n_fail++; $display("FAIL sync_fill31 got=%0d exp=0", FILL_CNT); end end
      if (c == 47) begin n_run++; if (FILL_CNT !== 16'd2) begin n_fail++; $display("FAIL sync_fill47 got=%0d exp=2", FILL_CNT); end end
`endif
      tick();
    end
  endtask

  task automatic test_first_data();
    logic [7:0] din [0:9];
    logic       vin [0:9];
    logic [7:0] exp_b [0:9];
    logic [7:0] e;
    logic       er;
    int s, b;
    din   = '{8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vin   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_b = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    do_reset();
    for (int c = 0; c < 48; c++) begin
      s = c / 8; b = c % 8;
      VALID_IN = vin[s+1]; DATA_IN = din[s+1];
      e  = exp_b[s];
      er = (b == 7) && (s >= 3);
      n_run++; if (DATA_OUT !== e[7-b]) begin n_fail++; $display("FAIL first_bit c=%0d got=%b exp=%b", c, DATA_OUT, e[7-b]); end
      n_run++; if (READY_OUT !== er) begin n_fail++; $display("FAIL first_ready c=%0d got=%b exp=%b", c, READY_OUT, er); end
      n_run++; if (LOCKED_OUT !== (s >= 4)) begin n_fail++; $display("FAIL first_locked c=%0d got=%b", c, LOCKED_OUT); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] din [0:9];
    logic       vin [0:9];
    logic [7:0] exp_b [0:9];
    logic [7:0] e;
    logic       er;
    int s, b;
    din   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    vin   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_b = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h3C, 8'hFF, 8'h00, 8'hBC, 8'hBC, 8'hBC};
    do_reset();
    for (int c = 0; c < 64; c++) begin
      s = c / 8; b = c % 8;
      VALID_IN = vin[s+1]; DATA_IN = din[s+1];
      e  = exp_b[s];
      er = (b == 7) && (s >= 3);
      n_run++; if (DATA_OUT !== e[7-b]) begin n_fail++; $display("FAIL b2b_bit c=%0d got=%b exp=%b", c, DATA_OUT, e[7-b]); end
      n_run++; if (READY_OUT !== er) begin n_fail++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, READY_OUT, er); end
      tick();
    end
  endtask

  // 0x81, gap, 0x7E, then 0xBC offered as real data, then an idle slot.
  task automatic test_gap_comma_data();
    logic [7:0] din [0:9];
    logic       vin [0:9];
    logic [7:0] exp_b [0:9];
    logic [7:0] e;
    logic       er;
    int s, b;
    din   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 8'h00, 8'h7E, 8'hBC, 8'h00, 8'h00};
    vin   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_b = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h81, 8'hBC, 8'h7E, 8'hBC, 8'hBC, 8'hBC};
    do_reset();
    for (int c = 0; c < 72; c++) begin
      s = c / 8; b = c % 8;
      VALID_IN = vin[s+1]; DATA_IN = din[s+1];
      e  = exp_b[s];
      er = (b == 7) && (s >= 3);
      n_run++; if (DATA_OUT !== e[7-b]) begin n_fail++; $display("FAIL gap_bit c=%0d got=%b exp=%b", c, DATA_OUT, e[7-b]); end
      n_run++; if (READY_OUT !== er) begin n_fail++; $display("FAIL gap_ready c=%0d got=%b exp=%b", c, READY_OUT, er); end
`ifdef PS_TX_FILL_STATS_EN
      if (c == 32) begin n_run++; if (FILL_CNT !== 16'd0) begin n_fail++; $display("FAIL gap_fill32 got=%0d exp=0", FILL_CNT); end end
      if (c == 40) begin n_run++; if (FILL_CNT !== 16'd1) begin n_fail++; $display("FAIL gap_fill40 got=%0d exp=1", FILL_CNT); end end
      if (c == 56) begin n_run++; if (FILL_CNT !== 16'd1) begin n_fail++; $display("FAIL gap_fill56 got=%0d exp=1", FILL_CNT); end end
      if (c == 64) begin n_run++; if (FILL_CNT !== 16'd2) begin n_fail++; $display("FAIL gap_fill64 got=%0d exp=2", FILL_CNT); end end
`endif
      tick();
    end
  endtask

  // Reset lands on bit 3 of a 0x55 byte; a full sync burst must follow release.
  task automatic test_mid_reset();
    logic [7:0] din [0:9];
    logic       vin [0:9];
    logic [7:0] exp_b [0:9];
    logic [7:0] e;
    logic       er;
    int s, b;
    din   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vin   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_b = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    do_reset();
    for (int c = 0; c < 36; c++) begin
      s = c / 8; b = c % 8;
      VALID_IN = vin[s+1]; DATA_IN = din[s+1];
      e = exp_b[s];
      n_run++; if (DATA_OUT !== e[7-b]) begin n_fail++; $display("FAIL mrst_pre_bit c=%0d got=%b exp=%b", c, DATA_OUT, e[7-b]); end
      if (c == 35) RESET = 1'b1;
      tick();
    end
    n_run++; if (DATA_OUT !== 1'b1) begin n_fail++; $display("FAIL mrst_data_out got=%b exp=1", DATA_OUT); end
    n_run++; if (READY_OUT !== 1'b0) begin n_fail++; $display("FAIL mrst_ready got=%b exp=0", READY_OUT); end
    n_run++; if (LOCKED_OUT !== 1'b0) begin n_fail++; $display("FAIL mrst_locked got=%b exp=0", LOCKED_OUT); end
    tick();
    RESET = 1'b0;
    // Source holds 0x55 valid from release; it must wait for the sync burst.
    vin = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    din = '{8'h00, 8'h55, 8'h55, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int c = 0; c < 48; c++) begin
      s = c / 8; b = c % 8;
      VALID_IN = vin[s+1]; DATA_IN = din[s+1];
      e  = exp_b[s];
      er = (b == 7) && (s >= 3);
      n_run++; if (DATA_OUT !== e[7-b]) begin n_fail++; $display("FAIL mrst_bit c=%0d got=%b exp=%b", c, DATA_OUT, e[7-b]); end
      n_run++; if (READY_OUT !== er) begin n_fail++; $display("FAIL mrst_ready c=%0d got=%b exp=%b", c, READY_OUT, er); end
      n_run++; if (LOCKED_OUT !== (s >= 4)) begin n_fail++; $display("FAIL mrst_locked c=%0d got=%b", c, LOCKED_OUT); end
`ifdef PS_TX_FILL_STATS_EN
      if (c == 47) begin n_run++; if (FILL_CNT !== 16'd1) begin n_fail++; $display("FAIL mrst_fill got=%0d exp=1", FILL_CNT); end end
`endif
      tick();
    end
  endtask

  initial begin
    RESET = 1'b1; VALID_IN = 1'b0; DATA_IN = 8'h00;
    test_reset();
    test_sync();
    test_first_data();
    test_back_to_back();
    test_gap_comma_data();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
